// File: rtl/lcd_byte_writer_pkg.sv
// Shared definitions for the character-LCD write path: FSM states, timing defaults
// (cycles at 50 MHz) and the command codes that need the long execution wait.
package lcd_defs;

  localparam int unsigned CNT_W = 17;

  localparam int unsigned LCD_SETUP_CYCLES     = 2;
  localparam int unsigned LCD_PULSE_CYCLES     = 12;
  localparam int unsigned LCD_HOLD_CYCLES      = 1;
  localparam int unsigned LCD_GAP_CYCLES       = 50;
  localparam int unsigned LCD_WAIT_CYCLES      = 2000;
  localparam int unsigned LCD_LONG_WAIT_CYCLES = 82000;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  typedef enum logic [3:0] {
    StIdle,
    StSetupH,
    StPulseH,
    StHoldH,
    StGap,
    StSetupL,
    StPulseL,
    StHoldL,
    StWait
  } lcd_state_e;

  // Clear and Home take ~1.64 ms to execute; everything else fits in 40 us.
  function automatic logic needs_long_wait(input logic [7:0] data, input logic rs,
                                           input logic nibble_only);
    return !rs && !nibble_only && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Valid/ready write request channel from the init/display FSMs to the LCD byte writer.
interface lcd_byte_writer_if;
  logic       iValid;
  logic       oReady;
  logic [7:0] iData;
  logic       iRS;
  logic       iNibbleOnly;
  logic       oDone;

  modport master (output iValid, iData, iRS, iNibbleOnly, input oReady, oDone);
  modport slave  (input iValid, iData, iRS, iNibbleOnly, output oReady, oDone);
endinterface

// File: rtl/lcd_byte_writer_cycle_timer.sv
// Up-counter with synchronous clear; o_last flags the cycle where the count reaches i_limit.
module lcd_cycle_timer
  import lcd_defs::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge Clock) begin
    if (Reset || i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_last = (r_count == i_limit);

endmodule

// File: rtl/lcd_byte_writer.sv
// Sends one command/data byte (or a single init nibble) over the Spartan-3E 4-bit LCD bus,
// generating E timing and the post-write execution wait, then pulses oDone.
module lcd_byte_writer
  import lcd_defs::*;
#(
  parameter int unsigned SETUP_CYCLES     = LCD_SETUP_CYCLES,
  parameter int unsigned PULSE_CYCLES     = LCD_PULSE_CYCLES,
  parameter int unsigned HOLD_CYCLES      = LCD_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES       = LCD_GAP_CYCLES,
  parameter int unsigned WAIT_CYCLES      = LCD_WAIT_CYCLES,
  parameter int unsigned LONG_WAIT_CYCLES = LCD_LONG_WAIT_CYCLES
) (
  input  logic                     Clock,
  input  logic                     Reset,
  lcd_byte_writer_if.slave         bus,
  output logic                     oLCD_Enabled,
  output logic                     oLCD_RegisterSelect,
  output logic                     oLCD_ReadWrite,
  output logic                     oLCD_StrataFlashControl,
  output logic [3:0]               oLCD_Data
);

  lcd_state_e       r_state, w_state_next;
  logic [7:0]       r_data, w_data_next;
  logic             r_nibble, w_nibble_next;
  logic             r_long, w_long_next;
  logic             r_lcd_e, w_lcd_e_next;
  logic             r_lcd_rs, w_lcd_rs_next;
  logic [3:0]       r_lcd_data, w_lcd_data_next;
  logic             r_done, w_done_next;
  logic [CNT_W-1:0] w_limit;
  logic             w_clear;
  logic             w_last;

  lcd_cycle_timer u_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_clear (w_clear),
    .i_limit (w_limit),
    .o_last  (w_last)
  );

  always_comb begin
    w_state_next    = r_state;
    w_data_next     = r_data;
    w_nibble_next   = r_nibble;
    w_long_next     = r_long;
    w_lcd_rs_next   = r_lcd_rs;
    w_lcd_data_next = r_lcd_data;
    w_done_next     = 1'b0;
    w_limit         = '0;

    case (r_state)
      StIdle: begin
        if (bus.iValid) begin
          w_state_next    = StSetupH;
          w_data_next     = bus.iData;
          w_nibble_next   = bus.iNibbleOnly;
          w_long_next     = needs_long_wait(bus.iData, bus.iRS, bus.iNibbleOnly);
          w_lcd_rs_next   = bus.iRS;
          w_lcd_data_next = bus.iNibbleOnly ? bus.iData[3:0] : bus.iData[7:4];
        end
      end
      StSetupH: begin
        w_limit = CNT_W'(SETUP_CYCLES - 1);
        if (w_last) w_state_next = StPulseH;
      end
      StPulseH: begin
        w_limit = CNT_W'(PULSE_CYCLES - 1);
        if (w_last) w_state_next = StHoldH;
      end
      StHoldH: begin
        w_limit = CNT_W'(HOLD_CYCLES - 1);
        if (w_last) w_state_next = r_nibble ? StWait : StGap;
      end
      StGap: begin
        w_limit = CNT_W'(GAP_CYCLES - 1);
        if (w_last) begin
          w_state_next    = StSetupL;
          w_lcd_data_next = r_data[3:0];
        end
      end
      StSetupL: begin
        w_limit = CNT_W'(SETUP_CYCLES - 1);
        if (w_last) w_state_next = StPulseL;
      end
      StPulseL: begin
        w_limit = CNT_W'(PULSE_CYCLES - 1);
        if (w_last) w_state_next = StHoldL;
      end
      StHoldL: begin
        w_limit = CNT_W'(HOLD_CYCLES - 1);
        if (w_last) w_state_next = StWait;
      end
      StWait: begin
        w_limit = r_long ? CNT_W'(LONG_WAIT_CYCLES - 1) : CNT_W'(WAIT_CYCLES - 1);
        if (w_last) begin
          w_state_next = StIdle;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase

    // E is registered from the next state so it rises/falls exactly on the pulse states.
    w_lcd_e_next = (w_state_next == StPulseH) || (w_state_next == StPulseL);
    w_clear      = (w_state_next != r_state) || (r_state == StIdle);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= StIdle;
      r_data     <= '0;
      r_nibble   <= 1'b0;
      r_long     <= 1'b0;
      r_lcd_e    <= 1'b0;
      r_lcd_rs   <= 1'b0;
      r_lcd_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_data     <= w_data_next;
      r_nibble   <= w_nibble_next;
      r_long     <= w_long_next;
      r_lcd_e    <= w_lcd_e_next;
      r_lcd_rs   <= w_lcd_rs_next;
      r_lcd_data <= w_lcd_data_next;
      r_done     <= w_done_next;
    end
  end

  assign bus.oReady              = (r_state == StIdle);
  assign bus.oDone               = r_done;
  assign oLCD_Enabled            = r_lcd_e;
  assign oLCD_RegisterSelect     = r_lcd_rs;
  assign oLCD_Data               = r_lcd_data;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: a transaction-level timeline model checked every cycle,
// plus directed scenarios with hand-computed latencies, pulse counts and nibble order.
module tb_lcd_byte_writer;

  // Shortened execution waits keep the run small; E/gap timing stays at the defaults.
  localparam int S  = 2;
  localparam int P  = 12;
  localparam int H  = 1;
  localparam int G  = 50;
  localparam int W  = 200;
  localparam int LW = 3000;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       lcd_e, lcd_rs, lcd_rw, lcd_sf;
  logic [3:0] lcd_d;

  lcd_byte_writer_if bus ();

  lcd_byte_writer #(
    .SETUP_CYCLES     (S),
    .PULSE_CYCLES     (P),
    .HOLD_CYCLES      (H),
    .GAP_CYCLES       (G),
    .WAIT_CYCLES      (W),
    .LONG_WAIT_CYCLES (LW)
  ) dut (
    .Clock                   (Clock),
    .Reset                   (Reset),
    .bus                     (bus),
    .oLCD_Enabled            (lcd_e),
    .oLCD_RegisterSelect     (lcd_rs),
    .oLCD_ReadWrite          (lcd_rw),
    .oLCD_StrataFlashControl (lcd_sf),
    .oLCD_Data               (lcd_d)
  );

  always #10 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: a write is a timeline of k = 0..len-1 cycles after the accepting edge.
  bit         m_valid = 0;
  bit         m_busy  = 0;
  int         m_k, m_len;
  logic [7:0] m_data;
  bit         m_rs, m_nib, m_long;
  bit         x_e, x_rs, x_done, x_ready;
  logic [3:0] x_d;

  int         done_cnt, e_hi_cnt, last_done_cyc, last_acc_cyc;
  logic [3:0] nib_q[$];
  bit         prev_e = 0;

  task automatic model_step();
    int lo_start;
    cyc++;
    if (Reset === 1'b1) begin
      m_valid = 1; m_busy = 0;
      x_e = 0; x_d = 4'h0; x_rs = 0; x_done = 0; x_ready = 1;
      return;
    end
    x_done = 0;
    if (m_busy) begin
      m_k++;
      if (m_k == m_len) begin
        m_busy = 0;
        x_done = 1;
      end
    end else if (bus.iValid === 1'b1) begin
      m_busy = 1; m_k = 0;
      m_data = bus.iData; m_rs = bus.iRS; m_nib = bus.iNibbleOnly;
      m_long = !m_rs && !m_nib && (m_data == 8'h01 || m_data == 8'h02);
      m_len  = m_nib ? (S + P + H + W) : (2 * (S + P + H) + G + (m_long ? LW : W));
    end
    x_ready = !m_busy;
    x_e = 0;
    if (m_busy) begin
      lo_start = S + P + H + G;
      x_rs = m_rs;
      if (m_nib) begin
        x_d = m_data[3:0];
        x_e = (m_k >= S && m_k < S + P);
      end else begin
        x_d = (m_k < lo_start) ? m_data[7:4] : m_data[3:0];
        x_e = (m_k >= S && m_k < S + P) || (m_k >= lo_start + S && m_k < lo_start + S + P);
      end
    end
  endtask

  task automatic compare_and_monitor();
    if (m_valid) begin
      n_vec++;
      if (bus.oReady !== x_ready || bus.oDone !== x_done || lcd_e !== x_e || lcd_rs !== x_rs ||
          lcd_d !== x_d || lcd_rw !== 1'b0 || lcd_sf !== 1'b1) begin
        n_err++;
        if (n_err <= 20)
          $display("FAIL cycle %0d bus: got rdy=%b done=%b e=%b rs=%b d=%h rw=%b sf=%b, want rdy=%b done=%b e=%b rs=%b d=%h rw=0 sf=1",
                   cyc, bus.oReady, bus.oDone, lcd_e, lcd_rs, lcd_d, lcd_rw, lcd_sf,
                   x_ready, x_done, x_e, x_rs, x_d);
      end
    end
    if (lcd_e === 1'b1 && !prev_e) nib_q.push_back(lcd_d);
    if (lcd_e === 1'b1) e_hi_cnt++;
    prev_e = (lcd_e === 1'b1);
    if (bus.oDone === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (bus.iValid === 1'b1 && bus.oReady === 1'b1 && Reset === 1'b0) last_acc_cyc = cyc + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    done_cnt = 0; e_hi_cnt = 0; nib_q.delete();
  endtask

  task automatic drive(input logic [7:0] d, input logic rs, input logic nib);
    bus.iData = d; bus.iRS = rs; bus.iNibbleOnly = nib; bus.iValid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic wait_accept(input string name);
    int g = 0;
    while (bus.oReady !== 1'b1 && g < 5000) begin
      @(posedge Clock); #1; g++;
    end
    if (g >= 5000) check({name, "_accept_timeout"}, 0, 1);
    @(posedge Clock); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic rs, input logic nib, input string name);
    drive(d, rs, nib);
    wait_accept(name);
    bus.iValid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lim);
    int g = 0;
    while (bus.oDone !== 1'b1 && g < lim) begin
      @(posedge Clock); #1; g++;
    end
    if (g >= lim) check({name, "_done_timeout"}, 0, 1);
    @(posedge Clock); #1;
  endtask

  initial begin
    int first_acc, first_done, g;
    Reset = 1'b1;
    bus.iValid = 1'b0; bus.iData = 8'h00; bus.iRS = 1'b0; bus.iNibbleOnly = 1'b0;
    last_done_cyc = 0; last_acc_cyc = 0;
    clear_mon();
    fork
      forever begin @(posedge Clock); model_step(); end
      forever begin @(negedge Clock); compare_and_monitor(); end
    join_none

    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("reset_ready", bus.oReady, 1);
    check("reset_e", lcd_e, 0);
    check("reset_data", lcd_d, 0);
    check("reset_done", bus.oDone, 0);

    // 1: byte 0x28, command
    clear_mon();
    send(8'h28, 1'b0, 1'b0, "t1");
    wait_done("t1", 400);
    check("t1_latency", last_done_cyc - last_acc_cyc, 280);
    check("t1_e_cycles", e_hi_cnt, 24);
    check("t1_pulses", nib_q.size(), 2);
    check("t1_nib0", nib_q[0], 4'h2);
    check("t1_nib1", nib_q[1], 4'h8);
    check("t1_done_count", done_cnt, 1);

    // 2: Clear as command (long wait) then as data (normal wait)
    send(8'h01, 1'b0, 1'b0, "t2a");
    wait_done("t2a", 4000);
    check("t2a_latency", last_done_cyc - last_acc_cyc, 3080);
    send(8'h01, 1'b1, 1'b0, "t2b");
    wait_done("t2b", 400);
    check("t2b_latency", last_done_cyc - last_acc_cyc, 280);

    // 3: nibble-only init write
    clear_mon();
    send(8'h03, 1'b0, 1'b1, "t3");
    wait_done("t3", 400);
    check("t3_latency", last_done_cyc - last_acc_cyc, 215);
    check("t3_e_cycles", e_hi_cnt, 12);
    check("t3_pulses", nib_q.size(), 1);
    check("t3_nib", nib_q[0], 4'h3);

    // 4: back-to-back with iValid held high
    clear_mon();
    drive(8'h0C, 1'b0, 1'b0);
    wait_accept("t4a");
    first_acc = last_acc_cyc;
    bus.iData = 8'h06;
    wait_accept("t4b");
    bus.iValid = 1'b0;
    first_done = last_done_cyc;
    check("t4_first_latency", first_done - first_acc, 280);
    check("t4_accept_on_done", last_acc_cyc - first_done, 1);
    wait_done("t4", 400);
    check("t4_second_latency", last_done_cyc - last_acc_cyc, 280);
    check("t4_e_cycles", e_hi_cnt, 48);
    check("t4_pulses", nib_q.size(), 4);
    check("t4_nib0", nib_q[0], 4'h0);
    check("t4_nib1", nib_q[1], 4'hC);
    check("t4_nib2", nib_q[2], 4'h0);
    check("t4_nib3", nib_q[3], 4'h6);
    check("t4_done_count", done_cnt, 2);

    // 5: reset during the low-nibble E pulse
    clear_mon();
    send(8'h41, 1'b1, 1'b0, "t5");
    g = 0;
    while (nib_q.size() < 2 && g < 200) begin
      @(posedge Clock); #1; g++;
    end
    repeat (3) begin @(posedge Clock); #1; end
    check("t5_in_pulse_l", lcd_e, 1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("t5_rst_e", lcd_e, 0);
    check("t5_rst_data", lcd_d, 0);
    check("t5_rst_rs", lcd_rs, 0);
    check("t5_rst_ready", bus.oReady, 1);
    Reset = 1'b0;
    repeat (400) begin @(posedge Clock); #1; end
    check("t5_no_done", done_cnt, 0);

    // 6: input churn while busy must not reach the bus
    clear_mon();
    send(8'h48, 1'b0, 1'b0, "t6");
    repeat (60) begin
      @(posedge Clock); #1;
      bus.iValid = ~bus.iValid;
      bus.iData  = 8'hFF;
    end
    bus.iValid = 1'b0;
    wait_done("t6", 400);
    repeat (20) begin @(posedge Clock); #1; end
    check("t6_pulses", nib_q.size(), 2);
    check("t6_nib0", nib_q[0], 4'h4);
    check("t6_nib1", nib_q[1], 4'h8);
    check("t6_done_count", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
